// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU between two requesters.
// One op is in flight at a time; the result returns as a one-cycle pulse.
module alu_arbiter #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  OP_WIDTH   = 4,
    parameter logic [OP_WIDTH-1:0] IDLE_OP    = 4'hF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0_VALID,
    output logic                  REQ0_READY,
    input  logic [DATA_WIDTH-1:0] REQ0_A,
    input  logic [DATA_WIDTH-1:0] REQ0_B,
    input  logic [OP_WIDTH-1:0]   REQ0_OP,
    output logic                  RSP0_VALID,
    output logic [DATA_WIDTH-1:0] RSP0_DATA,
    input  logic                  REQ1_VALID,
    output logic                  REQ1_READY,
    input  logic [DATA_WIDTH-1:0] REQ1_A,
    input  logic [DATA_WIDTH-1:0] REQ1_B,
    input  logic [OP_WIDTH-1:0]   REQ1_OP,
    output logic                  RSP1_VALID,
    output logic [DATA_WIDTH-1:0] RSP1_DATA,
    output logic [DATA_WIDTH-1:0] ALU_IN_A,
    output logic [DATA_WIDTH-1:0] ALU_IN_B,
    output logic [OP_WIDTH-1:0]   ALU_OP,
    input  logic [DATA_WIDTH-1:0] ALU_RESULT,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;

    logic win;
    logic gnt1;
    logic acc0;
    logic acc1;
    logic accept;
    logic capt;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_CAPT;
            S_CAPT: state_d = S_DONE;
            S_DONE: state_d = accept ? S_EXEC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / handshake logic; a tie goes to the port that did not win last
    always_comb begin
        win    = (state_q == S_IDLE) || (state_q == S_DONE);
        gnt1   = REQ1_VALID && (!REQ0_VALID || !last_q);
        acc0   = win && REQ0_VALID && !gnt1;
        acc1   = win && REQ1_VALID && gnt1;
        accept = acc0 || acc1;
        capt   = (state_q == S_CAPT);
        BUSY   = (state_q != S_IDLE);
        REQ0_READY = acc0;
        REQ1_READY = acc1;
    end

    always_comb begin
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        owner_d      = owner_q;
        last_d       = last_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        rsp0_valid_d = capt && !owner_q;
        rsp1_valid_d = capt && owner_q;
        if (accept) begin
            alu_a_d  = acc1 ? REQ1_A : REQ0_A;
            alu_b_d  = acc1 ? REQ1_B : REQ0_B;
            alu_op_d = acc1 ? REQ1_OP : REQ0_OP;
            owner_d  = acc1;
            last_d   = acc1;
        end
        if (rsp0_valid_d) begin
            rsp0_data_d = ALU_RESULT;
        end
        if (rsp1_valid_d) begin
            rsp1_data_d = ALU_RESULT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= IDLE_OP;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign ALU_IN_A   = alu_a_q;
    assign ALU_IN_B   = alu_b_q;
    assign ALU_OP     = alu_op_q;
    assign RSP0_VALID = rsp0_valid_q;
    assign RSP1_VALID = rsp1_valid_q;
    assign RSP0_DATA  = rsp0_data_q;
    assign RSP1_DATA  = rsp1_data_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit registered ALU between two requesters: port 0 is the processor core and port 1 is an auxiliary or peripheral master.
- Accepts one operation at a time over a valid/ready handshake, with round-robin arbitration.
- Drives the ALU operand and opcode inputs from internal registers and waits out the ALU's 1-cycle registered latency.
- Returns the result to the owning requester as a one-cycle response pulse.

Parameters:
- DATA_WIDTH, 8, operand and result width; must match the ALU.
- OP_WIDTH, 4, opcode width.
- IDLE_OP, 4'hF, opcode driven to the ALU after reset; it selects the ALU default, result = A.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- REQ0_VALID  input  1  requester 0 has an operation.
- REQ0_READY  output  1  requester 0 operation accepted this cycle.
- REQ0_A  input  DATA_WIDTH  requester 0 operand A.
- REQ0_B  input  DATA_WIDTH  requester 0 operand B.
- REQ0_OP  input  OP_WIDTH  requester 0 ALU opcode.
- RSP0_VALID  output  1  one-cycle result pulse for requester 0.
- RSP0_DATA  output  DATA_WIDTH  result for requester 0.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_OP, RSP1_VALID, RSP1_DATA: same as port 0, for requester 1.
- ALU_IN_A  output  DATA_WIDTH  to ALU operand A.
- ALU_IN_B  output  DATA_WIDTH  to ALU operand B.
- ALU_OP  output  OP_WIDTH  to ALU opcode.
- ALU_RESULT  input  DATA_WIDTH  registered ALU output.
- BUSY  output  1  high when state is not IDLE.

Behaviour:
- Clocking and reset: single clock domain; CLK and RESET are shared with the ALU. RESET is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - ALU_IN_A = 0, ALU_IN_B = 0, ALU_OP = IDLE_OP.
  - RSP0/1_VALID = 0, RSP0/1_DATA = 0, BUSY = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: operands are at the ALU inputs.
  - CAPT: ALU_RESULT is valid this cycle.
  - DONE: response pulse is out.
- Accept window: state in {IDLE, DONE}.
- Grant (combinational from the VALIDs):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester != last is granted.
  - REQk_READY = accept window && REQk_VALID && grant == k.
  - At most one READY is high per cycle; READY is never high while its VALID is low.
- Accept (VALID && READY at edge t):
  - ALU_IN_A/B/OP registers load REQk_A/B/OP.
  - owner <= k, last <= k.
  - state -> EXEC.
  - Operand and opcode inputs are sampled only at accept.
- EXEC (cycle t+1): the ALU registers its result at the end of the cycle; state -> CAPT.
- CAPT (cycle t+2): RSP<owner>_DATA <= ALU_RESULT, RSP<owner>_VALID <= 1, state -> DONE.
- DONE (cycle t+3):
  - RSP<owner>_VALID is high for exactly this cycle.
  - If a new accept occurs, state -> EXEC; otherwise state -> IDLE.
- Latency: accept edge to RSP_VALID high is 3 cycles. Back-to-back throughput is one operation per 3 cycles.
- Response rules:
  - No response backpressure; the requester must take the pulse.
  - RSPk_DATA holds its last value until the next response to k.
  - The other port's RSP_DATA is never disturbed.
- ALU_IN_A/B/OP hold the last issued values while IDLE. The ALU output is ignored outside CAPT.
- Opcodes:
  - All OP_WIDTH values are forwarded unmodified.
  - Opcodes 0xC–0xF return A.
  - Compare opcodes 0x9–0xB return 0x01 or 0x00.
  - Arithmetic wraps modulo 2^DATA_WIDTH (ALU behaviour, not altered here).
- Simultaneous events:
  - An accept in DONE coincides with the previous response pulse; both happen.
  - The same requester may be both responded to and re-accepted in one cycle.
- A requester that drops VALID before READY simply loses arbitration; no operation is recorded.
- RESET mid-operation (any state):
  - Next state = IDLE; the in-flight operation is discarded with no response pulse.
  - The pointer returns to last = 1.
  - The ALU is cleared by the same RESET.

Test Plan:
- Single op, port 0: A=0x05, B=0x03, OP=0x0 accepted at cycle 0 -> RSP0_VALID high only at cycle 3, RSP0_DATA=0x08; RSP1_VALID stays 0; BUSY high cycles 1–3.
- Tie, then alternation after reset:
  - Stimulus: both VALID held continuously. Port 0: A=0x10, B=0x11, OP=0x2. Port 1: A=0x10, B=0x04, OP=0x1.
  - Response: port 0 accepted first -> RSP0_DATA=0x10 (truncated 0x110). Port 1 accepted in the DONE cycle -> RSP1_DATA=0x0C.
  - Grants alternate 0,1,0,1 every 3 cycles.
- Back-to-back, single requester: four ops issued with REQ0_VALID held -> accepts at cycles 0, 3, 6, 9; RSP0_VALID at cycles 3, 6, 9, 12; only one READY high per accept.
- Compare and default opcodes:
  - OP=0x9, A=B=0x7A -> 0x01.
  - OP=0xA, A=0x02, B=0x09 -> 0x00.
  - OP=0xE, A=0x5C -> 0x5C.
- Reset mid-op: RESET pulsed in the EXEC cycle -> no RSP pulse; ALU_OP=0xF, BUSY=0 next cycle; a subsequent tie is granted to port 0.
- Dropped request: REQ1_VALID high for one cycle while an op is in EXEC, then low -> REQ1_READY never high; no port 1 response.
